// File: rtl/vga_plot_scanout.sv
// ----------------------------------------------------------------------------
// vga_plot_scanout
//
// Receives the pixel-plot stream from the fractal renderers and writes it into a
// 160x120, 3-bit-per-pixel on-chip framebuffer. It scans that buffer out as
// 640x480@60 VGA from the 50 MHz clock. Each stored pixel appears on screen as
// a 4x4 block. This module replaces the vendor VGA adapter in the top levels.
//
// Ports
//   clock        50 MHz system clock; all logic on the rising edge
//   reset        synchronous, active-high
//   x, y         plot coordinates (column 0..159, row 0..119)
//   colour       {R,G,B} colour of the plotted pixel
//   plot         write strobe, one pixel per clock, no backpressure
//   VGA_R/G/B    8-bit colour channels (all-ones or all-zeros)
//   VGA_HS/VS    horizontal / vertical sync, active-low
//   VGA_BLANK_N  low outside the visible region
//   VGA_SYNC_N   tied low
//   VGA_CLK      25 MHz pixel clock for the DAC
//   frame_start  one-clock pulse on the first output clock of pixel (0,0)
// ----------------------------------------------------------------------------
module vga_plot_scanout #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int SCALE  = 4,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       frame_start
);

    localparam int SCALE_SH = $clog2(SCALE);
    localparam int FB_SIZE  = FB_W * FB_H;

    localparam logic [7:0] X_LIM = 8'(FB_W);
    localparam logic [6:0] Y_LIM = 7'(FB_H);

    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] H_SYNC_S = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_E = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] V_SYNC_S = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_E = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic        pix_en;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;

    logic [2:0]  mem [0:FB_SIZE-1];
    logic [2:0]  rd_data;
    logic [14:0] wr_addr;
    logic [14:0] rd_addr;
    logic [14:0] wr_row;
    logic [14:0] rd_row;
    logic [14:0] rd_col;
    logic        wr_en;
    logic        visible;
    logic        hs_active;
    logic        vs_active;

    // Write address y*160 + x built from shifts; range checks keep stray
    // coordinates from wrapping onto a neighbouring row.
    assign wr_row  = {8'd0, y};
    assign wr_addr = (wr_row << 7) + (wr_row << 5) + {7'd0, x};
    assign wr_en   = plot && !reset && (x < X_LIM) && (y < Y_LIM);

    assign rd_row  = 15'(vcnt >> SCALE_SH);
    assign rd_col  = 15'(hcnt >> SCALE_SH);
    assign rd_addr = (rd_row << 7) + (rd_row << 5) + rd_col;

    assign visible   = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    assign hs_active = (hcnt >= H_SYNC_S) && (hcnt <= H_SYNC_E);
    assign vs_active = (vcnt >= V_SYNC_S) && (vcnt <= V_SYNC_E);

    assign VGA_SYNC_N = 1'b0;

    // Framebuffer. The read happens on the first clock of each pixel period.
    // Off-screen counter values would index past the array, so no read is
    // issued there. A same-clock write to the address being read is seen only
    // on the next read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= colour;
        end
        if (pix_en && visible) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Scan timing. Each pixel period is two clocks. On the pix_en clock the
    // read is issued. On the following clock the read data and the decode of
    // the same (hcnt,vcnt) are registered, and the counters step. So the
    // outputs for counter value k appear on clocks 2k+2 and 2k+3.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_en      <= 1'b1;
            hcnt        <= '0;
            vcnt        <= '0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_CLK     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            // VGA_CLK follows the inverse of the next phase. It is low while
            // outputs are fresh and rises mid-pixel.
            VGA_CLK     <= pix_en;
            frame_start <= 1'b0;
            if (!pix_en) begin
                VGA_R       <= (visible && rd_data[2]) ? 8'hFF : 8'h00;
                VGA_G       <= (visible && rd_data[1]) ? 8'hFF : 8'h00;
                VGA_B       <= (visible && rd_data[0]) ? 8'hFF : 8'h00;
                VGA_HS      <= ~hs_active;
                VGA_VS      <= ~vs_active;
                VGA_BLANK_N <= visible;
                frame_start <= (hcnt == 10'd0) && (vcnt == 10'd0);
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_scanout.sv
module tb_vga_plot_scanout;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;

    always #5 clock = ~clock;

    vga_plot_scanout dut (
        .clock       (clock),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_CLK     (VGA_CLK),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [2:0] rgb;
        logic       known;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic [9:0] h;
        logic [9:0] v;
    } exp_t;

    exp_t       sbq[$];
    exp_t       cur;
    exp_t       me;
    int         n = 0;
    int         tests = 0;
    int         fails = 0;
    int         phase = 0;
    logic [2:0] fbm [0:19199];
    bit         fbk [0:19199];
    int         mh, mv, midx;

    // Reference model. Clock n is the n-th clock after reset. Pixel period k
    // spans clocks 2k and 2k+1. Its screen position is h=k mod 800 and
    // v=(n/1600) mod 525. The framebuffer is sampled at clock 2k, before that
    // clock's plot.
    always @(posedge clock) begin
        if (reset) begin
            n = 0;
            sbq.delete();
        end else begin
            if (n % 2 == 0) begin
                mh = (n / 2) % 800;
                mv = (n / 1600) % 525;
                me.h = 10'(mh);
                me.v = 10'(mv);
                me.blank = (mh < 640) && (mv < 480);
                me.hs = !(mh >= 656 && mh <= 751);
                me.vs = !(mv >= 490 && mv <= 491);
                me.fs = (mh == 0) && (mv == 0);
                if (me.blank) begin
                    midx = (mv / 4) * 160 + mh / 4;
                    me.rgb = fbm[midx];
                    me.known = fbk[midx];
                end else begin
                    me.rgb = 3'b000;
                    me.known = 1'b1;
                end
                sbq.push_back(me);
            end
            if (plot && x < 8'd160 && y < 7'd120) begin
                fbm[int'(y) * 160 + int'(x)] = colour;
                fbk[int'(y) * 160 + int'(x)] = 1'b1;
            end
            n++;
        end
    end

    exp_t       ex;
    logic       eclk, efs;
    logic [23:0] ergb, grgb;
    logic       prev_hs = 1'b1;
    int         low_start = 0;
    bit         ok;

    // Monitor: compares every clock at the falling edge.
    always @(negedge clock) begin
        eclk = (n % 2 == 1);
        ok = 1'b1;
        if (n < 2) begin
            ex = '0;
            ex.known = 1'b1;
            ex.hs = 1'b1;
            ex.vs = 1'b1;
            efs = 1'b0;
        end else if (n % 2 == 0) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty n=%0d got no expectation required one", n);
                cur = '0;
                cur.known = 1'b0;
                cur.hs = 1'b1;
                cur.vs = 1'b1;
            end else begin
                cur = sbq.pop_front();
            end
            ex = cur;
            efs = cur.fs;
        end else begin
            ex = cur;
            efs = 1'b0;
        end
        ergb = {{8{ex.rgb[2]}}, {8{ex.rgb[1]}}, {8{ex.rgb[0]}}};
        grgb = {VGA_R, VGA_G, VGA_B};
        tests++;
        if (ex.known && grgb !== ergb) ok = 1'b0;
        if (VGA_HS !== ex.hs || VGA_VS !== ex.vs || VGA_BLANK_N !== ex.blank) ok = 1'b0;
        if (frame_start !== efs || VGA_CLK !== eclk || VGA_SYNC_N !== 1'b0) ok = 1'b0;
        if (!ok) begin
            fails++;
            $display("FAIL pixel n=%0d h=%0d v=%0d got rgb=%h hs=%b vs=%b bn=%b fs=%b clk=%b sn=%b required rgb=%h(known=%b) hs=%b vs=%b bn=%b fs=%b clk=%b sn=0",
                     n, ex.h, ex.v, grgb, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, VGA_CLK, VGA_SYNC_N,
                     ergb, ex.known, ex.hs, ex.vs, ex.blank, efs, eclk);
        end

        // Horizontal sync edge placement and width.
        if (prev_hs === 1'b1 && VGA_HS === 1'b0) begin
            tests++;
            low_start = n;
            if (n % 1600 != 1314) begin
                fails++;
                $display("FAIL hs_fall got clock %0d in line required 1314", n % 1600);
            end
        end
        if (prev_hs === 1'b0 && VGA_HS === 1'b1) begin
            tests++;
            if (n - low_start != 192) begin
                fails++;
                $display("FAIL hs_width got %0d clocks required 192", n - low_start);
            end
        end
        prev_hs = VGA_HS;

        // Directed spot checks with fixed colours from the stimulus.
        if (phase == 2) begin
            ergb = 24'hxxxxxx;
            case (n)
                2:    ergb = 24'hFF0000;
                10:   ergb = 24'h000000;
                6402: ergb = 24'h00FFFF;
                6482: ergb = 24'h0000FF;
                8082: ergb = 24'hFFFF00;
                default: ;
            endcase
            if (n == 2 || n == 10 || n == 6402 || n == 6482 || n == 8082) begin
                tests++;
                if (grgb !== ergb) begin
                    fails++;
                    $display("FAIL directed_rgb n=%0d got %h required %h", n, grgb, ergb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int guard;

    initial begin
        reset = 1'b1;
        plot = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Load rows 0..9 while the first frame scans (those reads are unknown).
        for (int yy = 0; yy < 10; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                plot = 1'b1;
                x = 8'(xx);
                y = 7'(yy);
                colour = 3'($urandom);
                tick();
            end
        end
        plot = 1'b1;
        x = 8'd0;   y = 7'd0; colour = 3'b100; tick();
        x = 8'd1;   y = 7'd0; colour = 3'b000; tick();
        x = 8'd0;   y = 7'd1; colour = 3'b011; tick();
        x = 8'd10;  y = 7'd1; colour = 3'b001; tick();
        x = 8'd160; y = 7'd0; colour = 3'b010; tick();
        x = 8'd0;   y = 7'd120; colour = 3'b111; tick();
        plot = 1'b0;

        // Restart the frame so the scan starts from the known pattern.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        phase = 2;

        guard = 0;
        while (n < 35200 && guard < 90000) begin
            guard++;
            reset = 1'b0;
            plot = 1'b0;
            if (phase == 2 && n == 6480) begin
                // Lands on the clock that reads framebuffer (10,1).
                plot = 1'b1;
                x = 8'd10;
                y = 7'd1;
                colour = 3'b110;
            end else if (phase == 2 && n == 19601) begin
                reset = 1'b1;
                phase = 3;
            end else if ($urandom_range(0, 2) == 0) begin
                plot = 1'b1;
                x = 8'($urandom_range(0, 175));
                if ($urandom_range(0, 9) == 0) y = 7'($urandom_range(120, 127));
                else y = 7'($urandom_range(2, 11));
                colour = 3'($urandom);
            end
            tick();
        end
        reset = 1'b0;
        plot = 1'b0;
        if (guard >= 90000) begin
            tests++;
            fails++;
            $display("FAIL run_budget got n=%0d required 35200", n);
        end
        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
